can_crc_unit: RTL

Parametrised serial CRC engine for the CAN/CAN-FD bit-stream path. It generalises the fixed 15-bit CAN CRC to any width, polynomial and initial value (CRC15, CRC17, CRC21). It adds a transmit mode that serialises the computed CRC MSB-first on the same bit strobe, and a receive-check flag for a zero residue. It sits between the bit-stuffing layer and the TX/RX frame FSMs; one instance per direction.

---
 rtl/can_crc_pkg.sv | 22 ++
 rtl/can_crc_unit_step.sv | 22 ++
 rtl/can_crc_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/can_crc_pkg.sv
// Shared types and CAN CRC constants for the serial CRC engine.
//   crc_state_e : engine mode (accumulate / serialise)
//   CAN_CRCxx_* : generator polynomials (without x^W) and initial values
package can_crc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        SEND = 1'b1
    } crc_state_e;

    localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
    localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
    localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

    localparam logic [14:0] CAN_CRC15_INIT = 15'h0;
    localparam logic [16:0] CAN_CRC17_INIT = 17'h10000;
    localparam logic [20:0] CAN_CRC21_INIT = 21'h100000;

    localparam int unsigned CRC_W_MIN = 8;
    localparam int unsigned CRC_W_MAX = 32;

endpackage

// File: rtl/can_crc_unit_step.sv
// Combinational single-bit LFSR step of the CAN CRC.
//   crc        : current CRC register
//   data       : stream bit to absorb
//   next_crc_c : CRC after absorbing data
module can_crc_step #(
    parameter int unsigned          CRC_W = 15,
    parameter logic [CRC_W-1:0]     POLY  = CRC_W'(15'h4599)
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             data,
    output logic [CRC_W-1:0] next_crc_c
);

    logic feedback_c;

    // Feedback is the stream bit XOR the bit shifted out of the MSB.
    always_comb begin
        feedback_c = data ^ crc[CRC_W-1];
        next_crc_c = {crc[CRC_W-2:0], 1'b0} ^ (feedback_c ? POLY : '0);
    end

endmodule

// File: rtl/can_crc_unit.sv
// Parametrised serial CRC engine for the CAN / CAN-FD bit stream.
// Accumulates destuffed bits, then optionally serialises the CRC MSB-first.
//   clk, reset        : clock, async active-high reset
//   clear             : synchronous reload to INIT, aborts serialisation
//   enable, data      : bit strobe and stream bit
//   send              : start serialising the current CRC (accumulate mode only)
//   crc, crc_zero     : CRC register and its zero-residue decode
//   tx_bit, tx_valid  : serialised CRC bit and its qualifier
//   tx_done           : pulse after the last CRC bit was consumed
module can_crc_unit
    import can_crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CAN_CRC15_POLY),
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             data,
    input  logic             send,
    output logic [CRC_W-1:0] crc,
    output logic             crc_zero,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_done
);

    localparam int unsigned CNT_W = $clog2(CRC_W);

    crc_state_e       state_q, state_n;
    logic [CRC_W-1:0] crc_q, crc_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             tx_valid_q, tx_valid_n;
    logic             tx_done_q, tx_done_n;
    logic [CRC_W-1:0] step_crc_c;

    can_crc_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc        (crc_q),
        .data       (data),
        .next_crc_c (step_crc_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ACC;
            crc_q      <= INIT;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            crc_q      <= crc_n;
            cnt_q      <= cnt_n;
            tx_valid_q <= tx_valid_n;
            tx_done_q  <= tx_done_n;
        end
    end

    // Next-state and output logic; clear dominates every other request.
    always_comb begin
        state_n    = state_q;
        crc_n      = crc_q;
        cnt_n      = cnt_q;
        tx_valid_n = tx_valid_q;
        tx_done_n  = 1'b0;

        if (clear) begin
            state_n    = ACC;
            crc_n      = INIT;
            cnt_n      = '0;
            tx_valid_n = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    // A bit strobed together with send is absorbed before serialising.
                    if (enable) begin
                        crc_n = step_crc_c;
                    end
                    if (send) begin
                        state_n    = SEND;
                        cnt_n      = CNT_W'(CRC_W - 1);
                        tx_valid_n = 1'b1;
                    end
                end
                SEND: begin
                    if (enable) begin
                        if (cnt_q == '0) begin
                            state_n    = ACC;
                            crc_n      = INIT;
                            tx_valid_n = 1'b0;
                            tx_done_n  = 1'b1;
                        end else begin
                            crc_n = {crc_q[CRC_W-2:0], 1'b0};
                            cnt_n = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ACC;
                end
            endcase
        end
    end

    assign crc      = crc_q;
    assign crc_zero = (crc_q == '0);
    assign tx_bit   = tx_valid_q & crc_q[CRC_W-1];
    assign tx_valid = tx_valid_q;
    assign tx_done  = tx_done_q;

endmodule
